// File: rtl/rs_pkg.sv
// Shared types and defaults for the RS(204,188) frame scheduler.
// Byte type, FSM state encoding and codeword geometry.
package rs_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEF_MSG_LEN    = 188;
  localparam int DEF_PAR_LEN    = 16;
  localparam int DEF_FRAME_LEN  = DEF_MSG_LEN + DEF_PAR_LEN;
  localparam int DEF_FIFO_DEPTH = 256;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/rs_byte_fifo.sv
// Single-clock byte FIFO with show-ahead read port.
// Push when full and pop when empty are ignored.
module rs_byte_fifo
  import rs_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_push,
  input  logic  i_pop,
  input  byte_t i_din,
  output byte_t o_dout,
  output logic  o_full,
  output logic  o_empty
);

  localparam int AW = $clog2(DEPTH);

  byte_t         r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic          w_wr_en;
  logic          w_rd_en;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_rd_en) r_rd <= r_rd + 1'b1;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/rs_frame_scheduler.sv
// Per-frame sequencer: Rx bytes -> RS encoder -> output FIFO -> Tx.
// Tx drain runs continuously, independent of the frame FSM.
module rs_frame_scheduler
  import rs_pkg::*;
#(
  parameter int MSG_LEN    = DEF_MSG_LEN,
  parameter int PAR_LEN    = DEF_PAR_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic  clk,
  input  logic  reset,
  input  byte_t rx_data,
  input  logic  rx_valid,
  output byte_t rs_din,
  output logic  rs_ce,
  output logic  rs_start,
  input  byte_t rs_dout,
  input  logic  rs_dout_valid,
  output byte_t tx_data,
  output logic  tx_start,
  input  logic  tx_busy,
  output logic  frame_done,
  output logic  overrun
);

  localparam int FRAME_LEN = MSG_LEN + PAR_LEN;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_msg_cnt;
  logic [4:0] r_par_cnt;
  logic [7:0] r_tx_cnt;
  byte_t      r_din;
  logic       r_ce;
  logic       r_start;
  byte_t      r_tx_data;
  logic       r_tx_start;
  logic       r_overrun;

  logic       w_open;
  logic       w_accept;
  logic       w_begin;
  logic       w_drop;
  logic       w_last_msg;
  logic       w_flush;
  logic       w_flush_last;
  logic       w_done;
  logic       w_fire;
  logic       w_full;
  logic       w_empty;
  logic       w_ovf;
  byte_t      w_head;

  assign w_open       = (r_state == IDLE) || (r_state == FEED);
  assign w_accept     = rx_valid && w_open;
  assign w_begin      = rx_valid && (r_state == IDLE);
  assign w_drop       = rx_valid && !w_open;
  assign w_last_msg   = w_accept && (r_state == FEED) &&
                        (r_msg_cnt == 8'(MSG_LEN - 1));
  assign w_flush      = (r_state == FLUSH);
  assign w_flush_last = w_flush && (r_par_cnt == 5'(PAR_LEN - 1));
  assign w_done       = (r_state == DRAIN) &&
                        (r_tx_cnt == 8'(FRAME_LEN));
  assign w_fire       = !w_empty && !tx_busy && !r_tx_start;
  assign w_ovf        = rs_dout_valid && w_full;

  rs_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (rs_dout_valid),
    .i_pop   (w_fire),
    .i_din   (rs_dout),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (rx_valid)     w_next = FEED;
      FEED:    if (w_last_msg)   w_next = FLUSH;
      FLUSH:   if (w_flush_last) w_next = DRAIN;
      DRAIN:   if (w_done)       w_next = IDLE;
      default:                   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_din      <= '0;
      r_ce       <= 1'b0;
      r_start    <= 1'b0;
      r_msg_cnt  <= '0;
      r_par_cnt  <= '0;
      r_tx_cnt   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_ce    <= w_accept || w_flush;
      r_din   <= w_accept ? rx_data : 8'h00;
      r_start <= w_begin;

      if (w_begin)       r_msg_cnt <= 8'd1;
      else if (w_accept) r_msg_cnt <= r_msg_cnt + 8'd1;

      if (w_begin)      r_par_cnt <= '0;
      else if (w_flush) r_par_cnt <= r_par_cnt + 5'd1;

      // A pop coinciding with the frame start is counted in the new frame.
      if (w_begin)     r_tx_cnt <= {7'd0, w_fire};
      else if (w_fire) r_tx_cnt <= r_tx_cnt + 8'd1;

      r_tx_start <= w_fire;
      if (w_fire) r_tx_data <= w_head;

      r_overrun <= r_overrun | w_drop | w_ovf;
    end
  end

  assign rs_din     = r_din;
  assign rs_ce      = r_ce;
  assign rs_start   = r_start;
  assign tx_data    = r_tx_data;
  assign tx_start   = r_tx_start;
  assign frame_done = w_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_rs_frame_scheduler.sv
// Randomised bench for rs_frame_scheduler with a queue-based reference model.
// Encoder and transmitter are modelled reactively inside the bench.
module tb_rs_frame_scheduler;

  localparam int ML    = 188;
  localparam int PL    = 16;
  localparam int FL    = ML + PL;
  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] rs_din;
  logic       rs_ce;
  logic       rs_start;
  logic [7:0] rs_dout;
  logic       rs_dout_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       frame_done;
  logic       overrun;

  always #5 clk = ~clk;

  rs_frame_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rs_din        (rs_din),
    .rs_ce         (rs_ce),
    .rs_start      (rs_start),
    .rs_dout       (rs_dout),
    .rs_dout_valid (rs_dout_valid),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .frame_done    (frame_done),
    .overrun       (overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Bench-side encoder and transmitter
  bit         inj = 0;
  bit         force_busy = 0;
  bit         rand_busy = 0;
  int         busy_len = 10;
  bit         enc_pend = 0;
  logic [7:0] enc_byte = 0;
  logic [7:0] enc_acc = 0;
  int         enc_k = 0;
  bit         saw_start = 0;
  int         bc = 0;

  always @(negedge clk) begin
    saw_start = (tx_start === 1'b1);
    if (reset) begin
      enc_pend = 0;
      enc_k    = 0;
      enc_acc  = 0;
    end else if (rs_ce) begin
      if (rs_start) begin
        enc_k   = 0;
        enc_acc = 0;
      end
      enc_pend = 1;
      if (enc_k < ML) begin
        enc_byte = rs_din;
        enc_acc  = enc_acc ^ rs_din;
      end else begin
        enc_byte = enc_acc ^ 8'(enc_k);
      end
      enc_k++;
    end else begin
      enc_pend = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    rs_dout_valid = inj | enc_pend;
    rs_dout       = inj ? 8'($urandom) : enc_byte;
    if (reset) bc = 0;
    else if (saw_start)
      bc = rand_busy ? int'($urandom_range(1, 10)) : busy_len;
    tx_busy = force_busy || (bc > 0);
    if (bc > 0) bc--;
  end

  // Reference model: counts per frame plus a byte queue for the FIFO
  int         m = 0;
  int         f = 0;
  int         t = 0;
  bit         ovr = 0;
  logic [7:0] q[$];
  bit         e_ce = 0;
  bit         e_st = 0;
  bit         e_txs = 0;
  logic [7:0] e_din = 0;
  logic [7:0] e_txd = 0;
  int         n_ce = 0;
  int         n_st = 0;
  int         n_txs = 0;
  int         n_done = 0;
  int         ncyc = 0;

  always @(negedge clk) begin
    bit         fire;
    bit         done_e;
    bit         full_e;
    bit         nce;
    bit         nst;
    logic [7:0] nd;
    logic [7:0] ntd;
    ncyc++;
    n_ce   += int'(rs_ce === 1'b1);
    n_st   += int'(rs_start === 1'b1);
    n_txs  += int'(tx_start === 1'b1);
    n_done += int'(frame_done === 1'b1);
    if (reset) begin
      check("rst_rs_ce", rs_ce, 0);
      check("rst_rs_start", rs_start, 0);
      check("rst_rs_din", rs_din, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overrun", overrun, 0);
      m = 0; f = 0; t = 0; ovr = 0;
      q.delete();
      e_ce = 0; e_st = 0; e_din = 0;
      e_txs = 0; e_txd = 0;
    end else begin
      if (e_txs) t++;
      done_e = (f == PL) && (t == FL);
      check("rs_ce", rs_ce, e_ce);
      check("rs_start", rs_start, e_st);
      if (e_ce) check("rs_din", rs_din, e_din);
      check("tx_start", tx_start, e_txs);
      check("tx_data", tx_data, e_txd);
      check("frame_done", frame_done, done_e);
      check("overrun", overrun, ovr);
      nce = 0; nst = 0; nd = 0;
      if (done_e) begin
        if (rx_valid) ovr = 1;
        m = 0; f = 0; t = 0;
      end else if (m == ML) begin
        if (rx_valid) ovr = 1;
        if (f < PL) begin
          nce = 1;
          f++;
        end
      end else if (rx_valid) begin
        nce = 1;
        nd  = rx_data;
        nst = (m == 0);
        if (m == 0) t = 0;
        m++;
      end
      full_e = (q.size() >= DEPTH);
      fire   = (q.size() != 0) && !tx_busy && !e_txs;
      ntd    = e_txd;
      if (fire) ntd = q.pop_front();
      if (rs_dout_valid) begin
        if (full_e) ovr = 1;
        else q.push_back(rs_dout);
      end
      e_ce = nce; e_st = nst; e_din = nd;
      e_txs = fire; e_txd = ntd;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int n, input int gmax, input bit ramp);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = ramp ? 8'(i) : 8'($urandom);
      step(1);
      rx_valid = 1'b0;
      step(int'($urandom_range(0, gmax)));
    end
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < budget) begin
      step(1);
      k++;
    end
    checks++;
    if (n_done == d0) begin
      errors++;
      $display("FAIL wait_done: no frame_done within %0d cycles", budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_ce, c_st, c_txs, c_done, cs;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    step(3);
    reset = 1'b0;
    step(2);

    // 1: ramp frame, fixed 10-cycle Tx busy
    c_ce = n_ce; c_st = n_st; c_txs = n_txs; c_done = n_done;
    send_frame(ML, 3, 1'b1);
    wait_done(6000);
    check("t1_ce_count", n_ce - c_ce, FL);
    check("t1_start_count", n_st - c_st, 1);
    check("t1_tx_count", n_txs - c_txs, FL);
    check("t1_done_count", n_done - c_done, 1);
    check("t1_overrun", overrun, 0);

    // 2: Rx bytes during FLUSH and DRAIN are dropped
    rand_busy = 1;
    c_ce = n_ce; c_txs = n_txs;
    send_frame(ML - 1, 3, 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    step(1);
    rx_data  = 8'($urandom);
    step(1);
    rx_valid = 1'b0;
    step(30);
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
    wait_done(6000);
    check("t2_overrun", overrun, 1);
    check("t2_ce_count", n_ce - c_ce, FL);
    check("t2_tx_count", n_txs - c_txs, FL);

    // 3: Tx stalled 500 cycles while the whole frame is encoded
    force_busy = 1;
    step(12);
    c_txs = n_txs;
    cs    = ncyc;
    send_frame(ML, 1, 1'b0);
    while (ncyc - cs < 500) step(1);
    check("t3_fifo_level", q.size(), FL);
    check("t3_no_tx_while_busy", n_txs - c_txs, 0);
    force_busy = 0;
    wait_done(6000);
    check("t3_tx_count", n_txs - c_txs, FL);

    // 4: reset mid-frame, then a fresh frame
    send_frame(101, 3, 1'b0);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("t4_overrun_cleared", overrun, 0);
    check("t4_ce_idle", rs_ce, 0);
    step(2);
    c_ce = n_ce; c_st = n_st; c_txs = n_txs; c_done = n_done;
    send_frame(ML, 3, 1'b0);
    wait_done(6000);
    check("t4_start_count", n_st - c_st, 1);
    check("t4_ce_count", n_ce - c_ce, FL);
    check("t4_tx_count", n_txs - c_txs, FL);
    check("t4_done_count", n_done - c_done, 1);

    // 5: two back-to-back frames
    c_st = n_st; c_txs = n_txs; c_done = n_done;
    send_frame(ML, 2, 1'b0);
    wait_done(6000);
    check("t5_start_first", n_st - c_st, 1);
    send_frame(ML, 2, 1'b0);
    wait_done(6000);
    check("t5_start_count", n_st - c_st, 2);
    check("t5_tx_count", n_txs - c_txs, 2 * FL);
    check("t5_done_count", n_done - c_done, 2);

    // 6: 300 encoder strobes into a stalled FIFO
    force_busy = 1;
    step(12);
    inj = 1;
    step(300);
    inj = 0;
    step(2);
    check("t6_fifo_level", q.size(), DEPTH);
    check("t6_overrun", overrun, 1);
    c_txs = n_txs;
    force_busy = 0;
    step(DEPTH * 12 + 20);
    check("t6_tx_count", n_txs - c_txs, DEPTH);
    check("t6_fifo_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
